// File: rtl/load_pkg.sv
// Shared types and helpers for the load stage: load-type codes, FSM states,
// type legality and (optional) alignment classification.
package load_pkg;

   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101
   } ld_type_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      WB   = 2'd3
   } state_e;

   function automatic logic is_legal_type(input logic [2:0] t);
      logic ok;
      ok = 1'b0;
      case (t)
         LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Halves need an even address, words need a 4-byte aligned address.
   function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      case (t)
         LD_LH, LD_LHU: bad = lo[0];
         LD_LW:         bad = (lo != 2'b00);
         default:       bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of a little-endian read word.
module load_extend (
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [2:0]  ld_type,
   output logic [31:0] result
);
   import load_pkg::*;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (lane)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      half_sel = lane[1] ? word[31:16] : word[15:0];

      result = word;
      case (ld_type)
         LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  result = {24'd0, byte_sel};
         LD_LH:   result = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  result = {16'd0, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load stage: address generation, one valid/ready word read, lane
// extension and a single-cycle register-file write. Optional alignment rejection
// is enabled by defining LOAD_MISALIGN_CHECK_EN.
module load_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_base,
   input  logic [15:0] in_offset,
   input  logic [4:0]  in_rd,
   input  logic [2:0]  in_type,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        reg_write,
   output logic [4:0]  write_reg,
   output logic [31:0] write_data,
   output logic        load_err
);
   import load_pkg::*;

   localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [4:0]  rd_q, rd_d;
   logic [2:0]  type_q, type_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [4:0]  wreg_q, wreg_d;
   logic [31:0] wdata_q, wdata_d;

   logic [31:0] new_addr;
   logic        reject;
   logic [31:0] ext_result;
   logic [15:0] cnt_inc;

   assign new_addr = in_base + {{16{in_offset[15]}}, in_offset};
   assign cnt_inc  = cnt_q + 16'd1;

`ifdef LOAD_MISALIGN_CHECK_EN
   assign reject = !is_legal_type(in_type) || is_misaligned(in_type, new_addr[1:0]);
`else
   assign reject = !is_legal_type(in_type);
`endif

   // Extension works on the live response so the result is latched on WAIT exit.
   load_extend u_extend (
      .word    (mem_rsp_data),
      .lane    (addr_q[1:0]),
      .ld_type (type_q),
      .result  (ext_result)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      type_d  = type_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (reject) begin
                  err_d = 1'b1;
               end else begin
                  state_d = REQ;
                  addr_d  = new_addr;
                  rd_d    = in_rd;
                  type_d  = in_type;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               state_d = WAIT;
               cnt_d   = 16'd0;
            end
         end
         WAIT: begin
            // A response arriving on the final counted cycle still wins.
            if (mem_rsp_valid) begin
               state_d = WB;
               wreg_d  = rd_q;
               wdata_d = ext_result;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TMO) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WB: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= 32'd0;
         rd_q    <= 5'd0;
         type_q  <= 3'd0;
         cnt_q   <= 16'd0;
         err_q   <= 1'b0;
         wreg_q  <= 5'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         type_q  <= type_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign mem_req_valid = (state_q == REQ);
   assign mem_addr      = {addr_q[31:2], 2'b00};
   assign reg_write     = (state_q == WB) && (rd_q != 5'd0);
   assign write_reg     = wreg_q;
   assign write_data    = wdata_q;
   assign load_err      = err_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a transaction-level expectation model
// and a per-cycle compare process.
module tb_load_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_base = 32'd0;
   logic [15:0] in_offset = 16'd0;
   logic [4:0]  in_rd = 5'd0;
   logic [2:0]  in_type = 3'd0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = 32'd0;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        load_err;

   load_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_base       (in_base),
      .in_offset     (in_offset),
      .in_rd         (in_rd),
      .in_type       (in_type),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .reg_write     (reg_write),
      .write_reg     (write_reg),
      .write_data    (write_data),
      .load_err      (load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_wr_q[$];
   int          exp_err = 0;
   logic [31:0] exp_addr = 32'd0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   function automatic bit m_legal(input logic [2:0] t);
      return (t == 3'b000) || (t == 3'b001) || (t == 3'b010) || (t == 3'b100) || (t == 3'b101);
   endfunction

   function automatic bit m_misal(input logic [2:0] t, input logic [31:0] a);
`ifdef LOAD_MISALIGN_CHECK_EN
      if (t == 3'b001 || t == 3'b101) return (a % 2) != 0;
      if (t == 3'b010) return (a % 4) != 0;
      return 1'b0;
`else
      return (t == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   // Arithmetic view of little-endian lane extraction and extension.
   function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] t);
      longint      v;
      int unsigned lane;
      lane = a % 4;
      case (t)
         3'b000, 3'b100: begin
            v = longint'((w / (32'd1 << (8 * lane))) % 256);
            if (t == 3'b000 && v >= 128) v = v - 256;
         end
         3'b001, 3'b101: begin
            v = (lane >= 2) ? longint'(w / 65536) : longint'(w % 65536);
            if (t == 3'b001 && v >= 32768) v = v - 65536;
         end
         default: v = longint'(w);
      endcase
      return v[31:0];
   endfunction

   // Per-cycle compare against the expectation queues.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (reg_write) begin
               if (exp_wr_q.size() == 0) begin
                  check1("unexpected_write", reg_write, 1'b0);
               end else begin
                  wr_t e;
                  e = exp_wr_q.pop_front();
                  check("write_reg", {27'd0, write_reg}, {27'd0, e.rd});
                  check("write_data", write_data, e.data);
               end
            end
            if (load_err) begin
               if (exp_err == 0) check1("unexpected_err", load_err, 1'b0);
               else exp_err--;
            end
            if (mem_req_valid) check("mem_addr_model", mem_addr, exp_addr & 32'hFFFF_FFFC);
         end
      end
   end

   task automatic do_load(input string tag, input logic [31:0] base, input logic [15:0] off,
                          input logic [4:0] rd, input logic [2:0] typ, input int rdy_dly,
                          input int rsp_dly, input logic [31:0] word, input bit rsp_en,
                          input bit use_lit, input logic [31:0] lit_data,
                          input logic [31:0] lit_addr);
      logic [31:0] a;
      logic [31:0] exp_d;
      bit          rej;
      int          c;
      wr_t         w;
      a     = base + {{16{off[15]}}, off};
      rej   = !m_legal(typ) || m_misal(typ, a);
      exp_d = model_ext(word, a, typ);
      if (rej || !rsp_en) begin
         exp_err++;
      end else if (rd != 5'd0) begin
         w.rd = rd;
         w.data = exp_d;
         exp_wr_q.push_back(w);
      end
      exp_addr = a;

      @(posedge clk); #1;
      in_valid = 1'b1; in_base = base; in_offset = off; in_rd = rd; in_type = typ;
      @(negedge clk);
      check1({tag, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_base = $urandom; in_offset = 16'h5A5A; in_rd = 5'd31; in_type = 3'b011;

      if (rej) begin
         @(negedge clk);
         check1({tag, "_reject_err"}, load_err, 1'b1);
         check1({tag, "_reject_noreq"}, mem_req_valid, 1'b0);
         check1({tag, "_reject_ready"}, in_ready, 1'b1);
         $display("load %s addr=%08h type=%03b -> rejected", tag, a, typ);
         return;
      end

      for (c = 0; c < 50; c++) begin
         mem_req_ready = (c >= rdy_dly);
         @(negedge clk);
         check1({tag, "_req_valid"}, mem_req_valid, 1'b1);
         check({tag, "_req_addr"}, mem_addr, {a[31:2], 2'b00});
         if (use_lit && c == 0) check({tag, "_addr_lit"}, mem_addr, lit_addr);
         check1({tag, "_busy"}, in_ready, 1'b0);
         @(posedge clk); #1;
         if (mem_req_ready) break;
      end
      if (c >= 50) check1({tag, "_req_bound"}, 1'b0, 1'b1);
      mem_req_ready = 1'b0;

      for (c = 0; c < 400; c++) begin
         mem_rsp_valid = rsp_en && (c >= rsp_dly);
         mem_rsp_data  = rsp_en && (c >= rsp_dly) ? word : ~word;
         @(negedge clk);
         if (!rsp_en && load_err) break;
         check1({tag, "_wait_noreq"}, mem_req_valid, 1'b0);
         check1({tag, "_wait_nowrite"}, reg_write, 1'b0);
         @(posedge clk); #1;
         if (mem_rsp_valid) break;
      end
      if (c >= 400) check1({tag, "_wait_bound"}, 1'b0, 1'b1);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;

      if (rsp_en) begin
         @(negedge clk);
         check1({tag, "_wb_strobe"}, reg_write, rd != 5'd0);
         if (use_lit && rd != 5'd0) check({tag, "_data_lit"}, write_data, lit_data);
         @(posedge clk); #1;
         @(negedge clk);
         check1({tag, "_single_pulse"}, reg_write, 1'b0);
         check1({tag, "_back_idle"}, in_ready, 1'b1);
         $display("load %s addr=%08h type=%03b rd=%0d -> data %08h", tag, a, typ, rd, exp_d);
      end else begin
         check({tag, "_timeout_cycles"}, c, TMO);
         check1({tag, "_timeout_ready"}, in_ready, 1'b1);
         $display("load %s addr=%08h type=%03b -> timeout after %0d", tag, a, typ, c);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check1("rst_in_ready", in_ready, 1'b1);
      check1("rst_req_valid", mem_req_valid, 1'b0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check1("rst_reg_write", reg_write, 1'b0);
      check("rst_write_reg", {27'd0, write_reg}, 32'd0);
      check("rst_write_data", write_data, 32'd0);
      check1("rst_load_err", load_err, 1'b0);

      // Best-case LW with negative offset.
      do_load("t1_lw", 32'h1000, 16'hFFFC, 5'd5, 3'b010, 0, 0, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 32'h0000_0FFC);
      // Lane selection and extension.
      do_load("t2_lb", 32'h2000, 16'h0003, 5'd6, 3'b000, 0, 0, 32'h80FF_FFFF, 1, 1, 32'hFFFF_FF80, 32'h2000);
      do_load("t2_lbu", 32'h2000, 16'h0003, 5'd7, 3'b100, 0, 0, 32'h80FF_FFFF, 1, 1, 32'h0000_0080, 32'h2000);
      do_load("t2_lhu", 32'h2000, 16'h0002, 5'd8, 3'b101, 0, 0, 32'h80FF_FFFF, 1, 1, 32'h0000_80FF, 32'h2000);
      do_load("t2_lh", 32'h2000, 16'h0002, 5'd8, 3'b001, 1, 1, 32'h80FF_1234, 1, 1, 32'hFFFF_80FF, 32'h2000);
      do_load("t2_lb1", 32'h2000, 16'h0001, 5'd3, 3'b000, 0, 2, 32'h0000_7F00, 1, 1, 32'h0000_007F, 32'h2000);
      do_load("t2_wrap", 32'h0000_0000, 16'hFFFF, 5'd4, 3'b100, 0, 0, 32'hAB00_0000, 1, 1, 32'h0000_00AB, 32'hFFFF_FFFC);
      // Back-pressure on request, delayed response.
      do_load("t3_slow", 32'h3000, 16'h0010, 5'd9, 3'b010, 5, 3, 32'h1234_5678, 1, 1, 32'h1234_5678, 32'h3010);
      // No response: abandoned after TMO cycles.
      do_load("t4_tmo", 32'h4000, 16'h0000, 5'd10, 3'b010, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
      // rd=0 runs the handshake but never strobes.
      do_load("t5_rd0", 32'h5000, 16'h0004, 5'd0, 3'b010, 0, 0, 32'hCAFE_F00D, 1, 0, 32'h0, 32'h0);
      do_load("t5_illegal", 32'h5000, 16'h0004, 5'd11, 3'b011, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0);

      // Reset while waiting, then a stale response.
      @(posedge clk); #1;
      exp_addr = 32'h6000;
      in_valid = 1'b1; in_base = 32'h6000; in_offset = 16'h0000; in_rd = 5'd12; in_type = 3'b010;
      @(posedge clk); #1 in_valid = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1 mem_req_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_0BAD;
      repeat (3) @(posedge clk);
      #1 mem_rsp_valid = 1'b0;
      @(negedge clk);
      check1("t6_rst_ready", in_ready, 1'b1);
      check("t6_rst_wdata", write_data, 32'd0);
      check("t6_rst_wreg", {27'd0, write_reg}, 32'd0);
      check1("t6_rst_noreq", mem_req_valid, 1'b0);
      $display("load t6_reset addr=00006000 -> aborted by reset");

      // Misaligned word: rejected with the check, aligned word read without.
      do_load("t6_misal", 32'h1000, 16'h0002, 5'd13, 3'b010, 0, 0, 32'h5555_AAAA, 1, 1, 32'h5555_AAAA, 32'h1000);

      repeat (4) @(posedge clk);
      #1;
      check("end_writes_pending", exp_wr_q.size(), 0);
      check("end_errs_pending", exp_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
